// File: rtl/key_deserializer_pkg.sv
// -----------------------------------------------------------------------------
// key_deserializer_pkg
// Shared types and constants for the serial key entry stage.
//   kd_state_t      : frame assembly state (idle / shifting a partial frame)
//   KD_FRAME_CNT_W  : width of the completed-frame counter
//   KD_KEY_W        : default key width
// -----------------------------------------------------------------------------
package key_deserializer_pkg;

    typedef enum logic [0:0] {
        KD_IDLE  = 1'b0,
        KD_SHIFT = 1'b1
    } kd_state_t;

    localparam int KD_FRAME_CNT_W = 8;
    localparam int KD_KEY_W       = 8;

endpackage : key_deserializer_pkg

// File: rtl/kd_idle_timer.sv
// -----------------------------------------------------------------------------
// kd_idle_timer
// Counts idle cycles between accepted bits of a partial frame.
// Ports:
//   clk     : clock
//   rstn    : asynchronous active-low reset
//   clr     : clear the count (has priority over en)
//   en      : advance the count by one
//   expired : count has reached TIMEOUT-1; the next idle cycle is the timeout
// -----------------------------------------------------------------------------
module kd_idle_timer #(
    parameter int TIMEOUT = 16
) (
    input  logic clk,
    input  logic rstn,
    input  logic clr,
    input  logic en,
    output logic expired
);

    logic [7:0] cnt_q;
    logic [7:0] cnt_d;

    always_comb begin
        cnt_d = cnt_q;
        if (clr) begin
            cnt_d = '0;
        end else if (en) begin
            cnt_d = cnt_q + 8'd1;
        end
    end

    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            cnt_q <= '0;
        end else begin
            cnt_q <= cnt_d;
        end
    end

    assign expired = (cnt_q == 8'(TIMEOUT - 1));

endmodule : kd_idle_timer

// File: rtl/key_deserializer.sv
// -----------------------------------------------------------------------------
// key_deserializer
// Assembles an MSB-first serial bit stream into a KEY_W-bit key for the unlock
// checker. Stale partial frames are dropped after TIMEOUT idle cycles.
// Ports:
//   clk         : clock, rising edge
//   rstn        : asynchronous active-low reset
//   bit_in      : serial key bit, sampled when bit_valid is 1
//   bit_valid   : qualifies bit_in, one bit per cycle
//   abort       : synchronous cancel of the current frame
//   key         : last completed key, held until the next completion
//   key_valid   : one-cycle pulse, key updated this cycle
//   busy        : a partial frame is in progress
//   timeout_err : one-cycle pulse, a partial frame was dropped by timeout
//   frame_cnt   : completed frame count, wraps at 256
// -----------------------------------------------------------------------------
module key_deserializer
    import key_deserializer_pkg::*;
#(
    parameter int KEY_W   = KD_KEY_W,
    parameter int TIMEOUT = 16
) (
    input  logic                      clk,
    input  logic                      rstn,
    input  logic                      bit_in,
    input  logic                      bit_valid,
    input  logic                      abort,
    output logic [KEY_W-1:0]          key,
    output logic                      key_valid,
    output logic                      busy,
    output logic                      timeout_err,
    output logic [KD_FRAME_CNT_W-1:0] frame_cnt
);

    localparam int CNT_W = $clog2(KEY_W + 1);

    kd_state_t                 state_q, state_d;
    logic [KEY_W-1:0]          shreg_q, shreg_d;
    logic [CNT_W-1:0]          bit_cnt_q, bit_cnt_d;
    logic [KEY_W-1:0]          key_q, key_d;
    logic                      key_valid_q, key_valid_d;
    logic                      busy_q;
    logic                      timeout_err_q, timeout_err_d;
    logic [KD_FRAME_CNT_W-1:0] frame_cnt_q, frame_cnt_d;

    logic                      tmr_clr;
    logic                      tmr_en;
    logic                      tmr_expired;
    logic [KEY_W-1:0]          shifted;

    assign shifted = {shreg_q[KEY_W-2:0], bit_in};

    kd_idle_timer #(
        .TIMEOUT (TIMEOUT)
    ) u_idle_timer (
        .clk     (clk),
        .rstn    (rstn),
        .clr     (tmr_clr),
        .en      (tmr_en),
        .expired (tmr_expired)
    );

    always_comb begin
        state_d       = state_q;
        shreg_d       = shreg_q;
        bit_cnt_d     = bit_cnt_q;
        key_d         = key_q;
        key_valid_d   = 1'b0;
        timeout_err_d = 1'b0;
        frame_cnt_d   = frame_cnt_q;
        tmr_clr       = 1'b0;
        tmr_en        = 1'b0;

        if (abort) begin
            // Abort wins over everything; a bit presented alongside is dropped.
            state_d   = KD_IDLE;
            bit_cnt_d = '0;
            tmr_clr   = 1'b1;
        end else begin
            case (state_q)
                KD_IDLE: begin
                    if (bit_valid) begin
                        state_d   = KD_SHIFT;
                        shreg_d   = shifted;
                        bit_cnt_d = CNT_W'(1);
                        tmr_clr   = 1'b1;
                    end
                end
                KD_SHIFT: begin
                    if (bit_valid) begin
                        // A bit in the would-be timeout cycle still counts.
                        shreg_d = shifted;
                        tmr_clr = 1'b1;
                        if (bit_cnt_q == CNT_W'(KEY_W - 1)) begin
                            key_d       = shifted;
                            key_valid_d = 1'b1;
                            frame_cnt_d = frame_cnt_q + 8'd1;
                            state_d     = KD_IDLE;
                            bit_cnt_d   = '0;
                        end else begin
                            bit_cnt_d = bit_cnt_q + CNT_W'(1);
                        end
                    end else if (tmr_expired) begin
                        timeout_err_d = 1'b1;
                        state_d       = KD_IDLE;
                        bit_cnt_d     = '0;
                        tmr_clr       = 1'b1;
                    end else begin
                        tmr_en = 1'b1;
                    end
                end
                default: begin
                    state_d   = KD_IDLE;
                    bit_cnt_d = '0;
                    tmr_clr   = 1'b1;
                end
            endcase
        end
    end

    // Register stage: every output comes straight from a flop.
    always_ff @(posedge clk or negedge rstn) begin
        if (!rstn) begin
            state_q       <= KD_IDLE;
            shreg_q       <= '0;
            bit_cnt_q     <= '0;
            key_q         <= '0;
            key_valid_q   <= 1'b0;
            busy_q        <= 1'b0;
            timeout_err_q <= 1'b0;
            frame_cnt_q   <= '0;
        end else begin
            state_q       <= state_d;
            shreg_q       <= shreg_d;
            bit_cnt_q     <= bit_cnt_d;
            key_q         <= key_d;
            key_valid_q   <= key_valid_d;
            busy_q        <= (state_d == KD_SHIFT);
            timeout_err_q <= timeout_err_d;
            frame_cnt_q   <= frame_cnt_d;
        end
    end

    assign key         = key_q;
    assign key_valid   = key_valid_q;
    assign busy        = busy_q;
    assign timeout_err = timeout_err_q;
    assign frame_cnt   = frame_cnt_q;

`ifdef FORMAL
    default clocking fv_cb @(posedge clk);
    endclocking
    default disable iff (!rstn);

    a_kv_pulse:     assert property (key_valid |=> !key_valid);
    a_busy_kv:      assert property (!(busy && key_valid));
    a_cnt_incr:     assert property (key_valid |-> frame_cnt == 8'($past(frame_cnt) + 8'd1));
    a_to_key_hold:  assert property (timeout_err |-> $stable(key));
    c_key_84:       cover property (key_valid && key == KEY_W'(8'h84));
`endif

endmodule : key_deserializer
